// File: rtl/sample_monitor_pkg.sv
// rtl/sample_monitor_pkg.sv - shared types, constants and helpers for sample_monitor
//
// Purpose: display mode encoding, display word width, saturating magnitude
// and the channel-select width helper used by the interface and the top.
// Ports: none (package).
package sample_monitor_pkg;

  typedef enum logic [1:0] {
    MODE_RAW      = 2'd0,
    MODE_PEAK     = 2'd1,
    MODE_MEAN     = 2'd2,
    MODE_MEAN_ABS = 2'd3
  } mode_t;

  localparam int DISP_W = 32;

  // Magnitude of a w-bit two's complement value held sign-extended in x.
  // The most-negative code has no positive counterpart, so it clips to
  // 2^(w-1)-1 instead of wrapping back to itself.
  function automatic logic [31:0] sat_abs(input logic signed [31:0] x, input int w);
    logic signed [31:0] most_neg;
    most_neg = -(32'sd1 <<< (w - 1));
    if (x == most_neg) begin
      return (32'd1 << (w - 1)) - 32'd1;
    end else if (x < 0) begin
      return -x;
    end else begin
      return x;
    end
  endfunction

  // Channel select width, never narrower than one bit.
  function automatic int sel_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sample_monitor_if.sv
// rtl/sample_monitor_if.sv - sample input and display output bundle
//
// Purpose: groups the sample strobe path, operator selection and display
// outputs of sample_monitor.
// Signals: data/data_rdy (samples + strobe), ch_sel/mode (operator selection),
// disp_val/disp_upd (display word + update pulse).
// Modports: master drives samples and selection, slave is the monitor.
interface sample_monitor_if #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 18
);
  import sample_monitor_pkg::*;

  localparam int CH_W = sel_w(NUM_CH);

  logic [NUM_CH-1:0][DATA_W-1:0] data;
  logic                          data_rdy;
  logic [CH_W-1:0]               ch_sel;
  logic [1:0]                    mode;
  logic [DISP_W-1:0]             disp_val;
  logic                          disp_upd;

  modport master (
    output data, data_rdy, ch_sel, mode,
    input  disp_val, disp_upd
  );

  modport slave (
    input  data, data_rdy, ch_sel, mode,
    output disp_val, disp_upd
  );

endinterface

// File: rtl/sample_monitor_stat.sv
// rtl/sample_monitor_stat.sv - per-channel window statistics (module sample_stat)
//
// Purpose: accumulates signed sum, magnitude sum and peak magnitude for one
// channel over a 2^LOG_WIN strobe window, latches the window results on the
// closing strobe and holds the last raw sample.
// Ports: clock, reset (sync, active-high), sample, strobe, close (closing
// strobe qualifier), raw, peak, mean, mean_abs (held results).
module sample_stat
  import sample_monitor_pkg::*;
#(
  parameter int DATA_W  = 18,
  parameter int LOG_WIN = 10
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [DATA_W-1:0]        sample,
  input  logic                     strobe,
  input  logic                     close,
  output logic [DATA_W-1:0]        raw,
  output logic [DATA_W-2:0]        peak,
  output logic signed [DATA_W-1:0] mean,
  output logic [DATA_W-2:0]        mean_abs
);

  localparam int SUM_W     = DATA_W + LOG_WIN;
  localparam int ABS_SUM_W = SUM_W - 1;
  localparam int ABS_W     = DATA_W - 1;

  logic signed [SUM_W-1:0] sum_acc, sum_next;
  logic [ABS_SUM_W-1:0]    abs_acc, abs_next;
  logic [ABS_W-1:0]        max_acc, max_next, abs_val;

  // Saturated magnitude always fits in DATA_W-1 bits.
  assign abs_val  = ABS_W'(sat_abs(DISP_W'(signed'(sample)), DATA_W));
  // "_next" values include the current sample so the closing strobe's
  // sample lands in the results it triggers.
  assign sum_next = sum_acc + SUM_W'(signed'(sample));
  assign abs_next = abs_acc + ABS_SUM_W'(abs_val);
  assign max_next = (abs_val > max_acc) ? abs_val : max_acc;

  always_ff @(posedge clock) begin
    if (reset) begin
      sum_acc  <= '0;
      abs_acc  <= '0;
      max_acc  <= '0;
      raw      <= '0;
      peak     <= '0;
      mean     <= '0;
      mean_abs <= '0;
    end else if (strobe) begin
      raw <= sample;
      if (close) begin
        peak     <= max_next;
        mean     <= DATA_W'(sum_next >>> LOG_WIN);
        mean_abs <= ABS_W'(abs_next >> LOG_WIN);
        sum_acc  <= '0;
        abs_acc  <= '0;
        max_acc  <= '0;
      end else begin
        sum_acc <= sum_next;
        abs_acc <= abs_next;
        max_acc <= max_next;
      end
    end
  end

endmodule

// File: rtl/sample_monitor.sv
// rtl/sample_monitor.sv - multi-channel window statistics with display mux
//
// Purpose: runs NUM_CH sample_stat channels on a shared window counter and
// drives one registered 32-bit display word for the selected channel/mode.
// Ports: clock, reset (sync, active-high), bus (sample_monitor_if.slave:
// data, data_rdy, ch_sel, mode in; disp_val, disp_upd out).
// Pipeline: strobe/selection registered in stage 1, display word in stage 2.
module sample_monitor
  import sample_monitor_pkg::*;
#(
  parameter int NUM_CH  = 4,
  parameter int DATA_W  = 18,
  parameter int LOG_WIN = 10
) (
  input  logic              clock,
  input  logic              reset,
  sample_monitor_if.slave   bus
);

  localparam int CH_W = sel_w(NUM_CH);

  logic [LOG_WIN-1:0] win_cnt;
  logic               close;

  logic [DATA_W-1:0]  raw_v      [NUM_CH];
  logic [DATA_W-2:0]  peak_v     [NUM_CH];
  logic [DATA_W-1:0]  mean_v     [NUM_CH];
  logic [DATA_W-2:0]  mean_abs_v [NUM_CH];

  logic [CH_W-1:0]    ch_sel_q, ch_sel_prev;
  mode_t              mode_q, mode_prev;
  logic               rdy_q, close_q;
  logic               sel_change, update;
  logic [DISP_W-1:0]  disp_next;

  // The strobe that wraps the counter back to zero closes the window.
  assign close = bus.data_rdy && (win_cnt == '1);

  always_ff @(posedge clock) begin
    if (reset) begin
      win_cnt <= '0;
    end else if (bus.data_rdy) begin
      win_cnt <= win_cnt + 1'b1;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    sample_stat #(
      .DATA_W  (DATA_W),
      .LOG_WIN (LOG_WIN)
    ) u_stat (
      .clock    (clock),
      .reset    (reset),
      .sample   (bus.data[g]),
      .strobe   (bus.data_rdy),
      .close    (close),
      .raw      (raw_v[g]),
      .peak     (peak_v[g]),
      .mean     (mean_v[g]),
      .mean_abs (mean_abs_v[g])
    );
  end

  // Stage 1: selection and strobe flags registered alongside the stat update,
  // so the stage-2 mux sees the selection and results of the same cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      ch_sel_q    <= '0;
      ch_sel_prev <= '0;
      mode_q      <= MODE_RAW;
      mode_prev   <= MODE_RAW;
      rdy_q       <= 1'b0;
      close_q     <= 1'b0;
    end else begin
      ch_sel_q    <= bus.ch_sel;
      ch_sel_prev <= ch_sel_q;
      mode_q      <= mode_t'(bus.mode);
      mode_prev   <= mode_q;
      rdy_q       <= bus.data_rdy;
      close_q     <= close;
    end
  end

  assign sel_change = (ch_sel_q != ch_sel_prev) || (mode_q != mode_prev);
  // A strobe and a selection change together collapse into one update.
  assign update     = sel_change || (rdy_q && ((mode_q == MODE_RAW) || close_q));

  // Out-of-range ch_sel matches no channel and leaves the word at zero.
  always_comb begin
    disp_next = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_sel_q == CH_W'(i)) begin
        case (mode_q)
          MODE_RAW:      disp_next = {{(DISP_W-DATA_W){raw_v[i][DATA_W-1]}}, raw_v[i]};
          MODE_PEAK:     disp_next = {{(DISP_W-DATA_W+1){1'b0}}, peak_v[i]};
          MODE_MEAN:     disp_next = {{(DISP_W-DATA_W){mean_v[i][DATA_W-1]}}, mean_v[i]};
          MODE_MEAN_ABS: disp_next = {{(DISP_W-DATA_W+1){1'b0}}, mean_abs_v[i]};
          default:       disp_next = '0;
        endcase
      end
    end
  end

  // Stage 2: output register.
  always_ff @(posedge clock) begin
    if (reset) begin
      bus.disp_val <= '0;
      bus.disp_upd <= 1'b0;
    end else begin
      bus.disp_upd <= update;
      if (update) begin
        bus.disp_val <= disp_next;
      end
    end
  end

endmodule

// File: tb/tb_sample_monitor.sv
// tb/tb_sample_monitor.sv - self-checking bench for sample_monitor
module tb_sample_monitor;

  localparam int NCH = 4;
  localparam int DW  = 18;
  localparam int LW  = 4;
  localparam int WIN = 1 << LW;
  localparam int MOST_NEG = -(1 << (DW - 1));

  logic clock = 1'b0;
  logic reset = 1'b1;

  sample_monitor_if #(.NUM_CH(NCH), .DATA_W(DW)) bus ();
  sample_monitor_if #(.NUM_CH(3),   .DATA_W(DW)) bus3 ();

  sample_monitor #(.NUM_CH(NCH), .DATA_W(DW), .LOG_WIN(LW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  sample_monitor #(.NUM_CH(3), .DATA_W(DW), .LOG_WIN(LW)) dut3 (
    .clock (clock),
    .reset (reset),
    .bus   (bus3)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  // Reference model: per-channel window contents and held results.
  int          smp     [NCH];
  int          raw_m   [NCH];
  int          peak_m  [NCH];
  int          mean_m  [NCH];
  int          mabs_m  [NCH];
  int          win_q   [NCH][$];
  int          prev_ch;
  int          prev_md;
  logic [31:0] exp_disp;
  logic [31:0] pipe_val [2];
  logic        pipe_upd [2];

  function automatic int sat_abs_m(int x);
    if (x == MOST_NEG) return -MOST_NEG - 1;
    return (x < 0) ? -x : x;
  endfunction

  function automatic int floor_div(int num, int den);
    int q;
    q = num / den;
    if ((num % den) != 0 && num < 0) q = q - 1;
    return q;
  endfunction

  function automatic logic [31:0] word_of(int ch, int md);
    logic [31:0] w;
    case (md)
      0:       w = raw_m[ch];
      1:       w = peak_m[ch];
      2:       w = mean_m[ch];
      default: w = mabs_m[ch];
    endcase
    return w;
  endfunction

  function automatic int rnd_sample();
    if ($urandom_range(0, 9) == 0) return MOST_NEG;
    return int'($urandom_range(0, (1 << DW) - 1)) + MOST_NEG;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic close_window();
    int sum, asum, mx, a;
    for (int c = 0; c < NCH; c++) begin
      sum = 0; asum = 0; mx = 0;
      foreach (win_q[c][k]) begin
        sum  += win_q[c][k];
        a     = sat_abs_m(win_q[c][k]);
        asum += a;
        if (a > mx) mx = a;
      end
      peak_m[c] = mx;
      mean_m[c] = floor_div(sum, WIN);
      mabs_m[c] = asum / WIN;
      win_q[c].delete();
    end
  endtask

  // One cycle: check outputs caused by the step two cycles back, then drive
  // this cycle's inputs (smp[] holds the samples) and predict their effect.
  task automatic step(input logic rdy, input int ch, input int md);
    logic changed, closed, upd;
    @(negedge clock);
    check("disp_upd", {31'b0, bus.disp_upd}, {31'b0, pipe_upd[0]});
    check("disp_val", bus.disp_val, pipe_val[0]);
    bus.data_rdy = rdy;
    for (int i = 0; i < NCH; i++) bus.data[i] = DW'(smp[i]);
    bus.ch_sel = 2'(ch);
    bus.mode   = 2'(md);
    changed = (ch != prev_ch) || (md != prev_md);
    closed  = 1'b0;
    if (rdy) begin
      for (int i = 0; i < NCH; i++) begin
        raw_m[i] = smp[i];
        win_q[i].push_back(smp[i]);
      end
      if (win_q[0].size() == WIN) begin
        close_window();
        closed = 1'b1;
      end
    end
    upd = changed || (rdy && (md == 0 || closed));
    if (upd) exp_disp = word_of(ch, md);
    prev_ch = ch;
    prev_md = md;
    pipe_upd[0] = pipe_upd[1];
    pipe_val[0] = pipe_val[1];
    pipe_upd[1] = upd;
    pipe_val[1] = exp_disp;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    bus.data_rdy  = 1'b0;
    bus.ch_sel    = '0;
    bus.mode      = '0;
    bus3.data_rdy = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    for (int c = 0; c < NCH; c++) begin
      raw_m[c] = 0; peak_m[c] = 0; mean_m[c] = 0; mabs_m[c] = 0;
      win_q[c].delete();
      smp[c] = 0;
    end
    prev_ch = 0; prev_md = 0; exp_disp = '0;
    for (int k = 0; k < 2; k++) begin
      pipe_upd[k] = 1'b0;
      pipe_val[k] = '0;
    end
    check("reset_disp_val", bus.disp_val, 32'h0);
    check("reset_disp_upd", {31'b0, bus.disp_upd}, 32'h0);
  endtask

  task automatic set_rand();
    for (int i = 0; i < NCH; i++) smp[i] = rnd_sample();
  endtask

  initial begin
    int ch, md;
    bus.data = '0; bus.data_rdy = 1'b0; bus.ch_sel = '0; bus.mode = '0;
    bus3.data = '0; bus3.data_rdy = 1'b0; bus3.ch_sel = 2'd3; bus3.mode = 2'd0;

    do_reset();

    // Ramp on ch0, mean of 0..15 floors to 7.
    step(1'b0, 0, 2);
    for (int i = 0; i < WIN; i++) begin
      set_rand(); smp[0] = i;
      step(1'b1, 0, 2);
    end
    step(1'b0, 0, 2); step(1'b0, 0, 2);
    check("ramp_mean", bus.disp_val, 32'h7);
    step(1'b0, 0, 3); step(1'b0, 0, 3); step(1'b0, 0, 3);
    check("ramp_mean_abs", bus.disp_val, 32'h7);
    step(1'b0, 0, 1); step(1'b0, 0, 1); step(1'b0, 0, 1);
    check("ramp_peak", bus.disp_val, 32'hF);

    // Constant -3 on ch2.
    for (int i = 0; i < WIN; i++) begin
      set_rand(); smp[2] = -3;
      step(1'b1, 2, 0);
    end
    step(1'b0, 2, 0); step(1'b0, 2, 0);
    check("neg_raw", bus.disp_val, 32'hFFFFFFFD);
    step(1'b0, 2, 2); step(1'b0, 2, 2); step(1'b0, 2, 2);
    check("neg_mean", bus.disp_val, 32'hFFFFFFFD);
    step(1'b0, 2, 3); step(1'b0, 2, 3); step(1'b0, 2, 3);
    check("neg_mean_abs", bus.disp_val, 32'h3);
    step(1'b0, 2, 1); step(1'b0, 2, 1); step(1'b0, 2, 1);
    check("neg_peak", bus.disp_val, 32'h3);

    // Most-negative code once on ch1.
    for (int i = 0; i < WIN; i++) begin
      for (int c = 0; c < NCH; c++) smp[c] = 0;
      if (i == 5) smp[1] = MOST_NEG;
      step(1'b1, 1, 1);
    end
    step(1'b0, 1, 1); step(1'b0, 1, 1);
    check("most_neg_peak", bus.disp_val, 32'h0001FFFF);

    // Selection change mid-window, then finish the window.
    set_rand();
    step(1'b1, 3, 2);
    for (int i = 0; i < 5; i++) begin set_rand(); step(1'b1, 0, 2); end
    step(1'b0, 3, 1); step(1'b0, 3, 1); step(1'b0, 3, 1);
    for (int i = 0; i < 10; i++) begin set_rand(); step(1'b1, 3, 1); end
    step(1'b0, 3, 1); step(1'b0, 3, 1);

    // Randomized traffic with occasional selection changes.
    ch = 0; md = 0;
    for (int i = 0; i < 120; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        ch = int'($urandom_range(0, NCH - 1));
        md = int'($urandom_range(0, 3));
      end
      set_rand();
      step(($urandom_range(0, 3) != 0), ch, md);
    end
    step(1'b0, ch, md); step(1'b0, ch, md);

    // Reset mid-window, then a full window of 5.
    for (int i = 0; i < 8; i++) begin set_rand(); step(1'b1, 0, 2); end
    do_reset();
    step(1'b0, 0, 2);
    for (int i = 0; i < WIN; i++) begin
      for (int c = 0; c < NCH; c++) smp[c] = 5;
      step(1'b1, 0, 2);
    end
    step(1'b0, 0, 2); step(1'b0, 0, 2);
    check("post_reset_mean", bus.disp_val, 32'h5);
    step(1'b0, 0, 2); step(1'b0, 0, 2);

    // Three-channel instance: out-of-range channel, strobes every cycle.
    for (int k = 0; k < 36; k++) begin
      @(negedge clock);
      check("oor_disp_upd", {31'b0, bus3.disp_upd}, {31'b0, (k >= 2 && k <= 33)});
      check("oor_disp_val", bus3.disp_val, 32'h0);
      bus3.data_rdy = (k < 32);
      for (int c = 0; c < 3; c++) bus3.data[c] = DW'(rnd_sample());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
